// File: rtl/blockmem_pkg.sv
// Shared definitions for the blockmem front-ends and wrappers: width helpers
// and the response kind carried alongside read data.
package blockmem_pkg;

  function automatic int pad_width(input int data_width);
    return (data_width + 7) & ~7;
  endfunction

  function automatic int we_width(input int padded_width, input int bw_enable);
    return (((padded_width - 1) / 8) * bw_enable) + 1;
  endfunction

  typedef enum logic {
    RSP_READ  = 1'b0,
    RSP_WRITE = 1'b1
  } rsp_kind_e;

endpackage

// File: rtl/blockmem_1p_initiator_if.sv
// Request/response stream plus the single memory port it drives. The master
// side is the requester together with the memory instance behind the port.
interface blockmem_1p_initiator_if #(
  parameter int G_DATAWIDTH = 32,
  parameter int G_ADDRWIDTH = 10,
  parameter int G_WEWIDTH   = 1
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [G_ADDRWIDTH-1:0] req_addr;
  logic [G_DATAWIDTH-1:0] req_wdata;
  logic [G_WEWIDTH-1:0]   req_wstrb;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic                   rsp_write;
  logic [G_DATAWIDTH-1:0] rsp_rdata;
  logic                   ena;
  logic [G_WEWIDTH-1:0]   wea;
  logic [G_ADDRWIDTH-1:0] addra;
  logic [G_DATAWIDTH-1:0] dina;
  logic [G_DATAWIDTH-1:0] douta;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready, douta,
    input  req_ready, rsp_valid, rsp_write, rsp_rdata, ena, wea, addra, dina
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready, douta,
    output req_ready, rsp_valid, rsp_write, rsp_rdata, ena, wea, addra, dina
  );
endinterface

// File: rtl/blockmem_rsp_fifo.sv
// Small synchronous FIFO built as a shift register so the head entry is
// always a flop output. Pushes into a full FIFO without a pop are dropped.
module blockmem_rsp_fifo #(
  parameter int G_DEPTH = 3,
  parameter int G_WIDTH = 33
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [G_WIDTH-1:0] push_data,
  input  logic               pop,
  output logic               empty,
  output logic [G_WIDTH-1:0] head
);
  localparam int C_CNTW = $clog2(G_DEPTH + 1);

  logic [G_WIDTH-1:0] entries     [G_DEPTH];
  logic [G_WIDTH-1:0] entries_nxt [G_DEPTH];
  logic [C_CNTW-1:0]  count;
  logic [C_CNTW-1:0]  count_nxt;
  logic               do_push;
  logic               do_pop;

  assign do_pop  = pop & (count != '0);
  assign do_push = push & ((count != C_CNTW'(G_DEPTH)) | do_pop);

  // NOTE: every variable gets a default before any branch, so no latch is
  // inferred; blocking assignments here build the next state in order (shift,
  // then insert at the post-pop fill level).
  always_comb begin
    entries_nxt = entries;
    count_nxt   = count;
    if (do_pop) begin
      for (int i = 0; i < G_DEPTH - 1; i++) entries_nxt[i] = entries[i+1];
      count_nxt = count - C_CNTW'(1);
    end
    if (do_push) begin
      for (int i = 0; i < G_DEPTH; i++) begin
        if (C_CNTW'(i) == count_nxt) entries_nxt[i] = push_data;
      end
      count_nxt = count_nxt + C_CNTW'(1);
    end
  end

  // NOTE: the storage is reset too; at this depth it is a handful of flops and
  // it guarantees the head reads as zero straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      for (int i = 0; i < G_DEPTH; i++) entries[i] <= '0;
    end else begin
      count   <= count_nxt;
      entries <= entries_nxt;
    end
  end

  assign empty = (count == '0);
  assign head  = entries[0];

endmodule

// File: rtl/blockmem_1p_initiator.sv
// Valid/ready front-end for one blockmem port: drives the memory straight from
// accepted requests and returns in-order responses, credit-limited to the FIFO.
module blockmem_1p_initiator
  import blockmem_pkg::*;
#(
  parameter int G_DATAWIDTH = 32,
  parameter int G_MEMDEPTH  = 1024,
  parameter int G_BWENABLE  = 0,
  parameter int G_RDLATENCY = 1,
  parameter int G_ADDRWIDTH = $clog2(G_MEMDEPTH),
  parameter int G_PADWIDTH  = pad_width(G_DATAWIDTH),
  parameter int G_WEWIDTH   = we_width(G_PADWIDTH, G_BWENABLE)
) (
  input logic                    clk,
  input logic                    rst,
  blockmem_1p_initiator_if.slave bus
);
  localparam int C_DEPTH = G_RDLATENCY + 2;
  localparam int C_CREDW = $clog2(C_DEPTH + 1);

  typedef struct packed {
    rsp_kind_e              kind;
    logic [G_DATAWIDTH-1:0] rdata;
  } rsp_entry_t;

  logic [C_CREDW-1:0]     credits;
  logic                   accept;
  logic                   pop;
  logic [G_RDLATENCY-1:0] tag_valid;
  logic [G_RDLATENCY-1:0] tag_write;
  logic                   fifo_empty;
  rsp_entry_t             push_entry;
  rsp_entry_t             head_entry;

  assign bus.req_ready = ~rst & (credits != '0);
  assign accept        = bus.req_valid & bus.req_ready;
  assign pop           = bus.rsp_valid & bus.rsp_ready;

  assign bus.ena   = accept;
  assign bus.wea   = (accept & bus.req_write) ? bus.req_wstrb : '0;
  assign bus.addra = bus.req_addr;
  assign bus.dina  = bus.req_wdata;

  // A credit is a reserved FIFO slot: taken at accept, returned at pop, so a
  // read is never issued unless its data has somewhere to land.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits   <= C_CREDW'(C_DEPTH);
      tag_valid <= '0;
      tag_write <= '0;
    end else begin
      if (accept && !pop) credits <= credits - C_CREDW'(1);
      else if (pop && !accept) credits <= credits + C_CREDW'(1);
      tag_valid[0] <= accept;
      tag_write[0] <= bus.req_write;
      for (int i = 1; i < G_RDLATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_write[i] <= tag_write[i-1];
      end
    end
  end

  always_comb begin
    push_entry.kind  = rsp_kind_e'(tag_write[G_RDLATENCY-1]);
    push_entry.rdata = tag_write[G_RDLATENCY-1] ? '0 : bus.douta;
  end

  blockmem_rsp_fifo #(
    .G_DEPTH (C_DEPTH),
    .G_WIDTH ($bits(rsp_entry_t))
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tag_valid[G_RDLATENCY-1]),
    .push_data (push_entry),
    .pop       (pop),
    .empty     (fifo_empty),
    .head      (head_entry)
  );

  assign bus.rsp_valid = ~fifo_empty;
  assign bus.rsp_write = (head_entry.kind == RSP_WRITE);
  assign bus.rsp_rdata = head_entry.rdata;

endmodule

// File: tb/tb_blockmem_1p_initiator.sv
// Bench for blockmem_1p_initiator: directed scenarios plus randomized traffic,
// with a queue-based scoreboard fed by an array reference memory.
module tb_blockmem_1p_initiator;
  localparam int DW      = 32;
  localparam int DEPTH   = 1024;
  localparam int BWEN    = 1;
  localparam int LAT     = 1;
  localparam int AW      = 10;
  localparam int WEW     = 4;
  localparam int C_DEPTH = LAT + 2;
  localparam int N_RAND  = 10000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  blockmem_1p_initiator_if #(.G_DATAWIDTH(DW), .G_ADDRWIDTH(AW), .G_WEWIDTH(WEW)) bus ();

  blockmem_1p_initiator #(
    .G_DATAWIDTH (DW),
    .G_MEMDEPTH  (DEPTH),
    .G_BWENABLE  (BWEN),
    .G_RDLATENCY (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory instance model: byte-enabled writes, read-first, LAT register stages.
  bit [DW-1:0] ram [DEPTH];
  bit [DW-1:0] rd_pipe [LAT];
  always @(posedge clk) begin
    if (bus.ena) begin
      for (int b = 0; b < WEW; b++)
        if (bus.wea[b]) ram[bus.addra][8*b +: 8] <= bus.dina[8*b +: 8];
      rd_pipe[0] <= ram[bus.addra];
    end
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.douta = rd_pipe[LAT-1];

  // Reference: what the memory should hold, and the responses owed in order.
  typedef struct {
    bit          write;
    logic [DW-1:0] rdata;
  } exp_t;

  bit [DW-1:0] ref_mem [DEPTH];
  exp_t        exp_q [$];
  int unsigned rsp_cyc_q [$];

  int unsigned cyc = 0;
  int n_checks = 0;
  int n_pass   = 0;
  int n_rsp    = 0;
  int unsigned acc_cyc = 0;
  logic [DW-1:0] last_rdata = '0;
  bit  last_write = 1'b0;
  bit  prev_stall = 1'b0;
  logic [DW+1:0] prev_rsp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic        acc;
    logic [WEW-1:0] exp_we;
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("rsp_stable", {bus.rsp_valid, bus.rsp_write, bus.rsp_rdata}, prev_rsp);
      prev_stall = bus.rsp_valid & ~bus.rsp_ready;
      prev_rsp   = {bus.rsp_valid, bus.rsp_write, bus.rsp_rdata};

      if (bus.rsp_valid && bus.rsp_ready) begin
        rsp_cyc_q.push_back(cyc);
        n_rsp++;
        last_rdata = bus.rsp_rdata;
        last_write = bus.rsp_write;
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_write", bus.rsp_write, e.write);
          check("rsp_rdata", bus.rsp_rdata, e.rdata);
        end
      end

      acc = bus.req_valid & bus.req_ready;
      if (bus.ena || acc) check("ena_is_accept", bus.ena, acc);
      if (acc) begin
        exp_we = bus.req_write ? bus.req_wstrb : '0;
        check("wea", bus.wea, exp_we);
        check("addra", bus.addra, bus.req_addr);
        if (bus.req_write) begin
          check("dina", bus.dina, bus.req_wdata);
          for (int b = 0; b < WEW; b++)
            if (bus.req_wstrb[b]) ref_mem[bus.req_addr][8*b +: 8] = bus.req_wdata[8*b +: 8];
          exp_q.push_back('{write: 1'b1, rdata: '0});
        end else begin
          exp_q.push_back('{write: 1'b0, rdata: ref_mem[bus.req_addr]});
        end
        acc_cyc = cyc;
      end
    end
  end

  task automatic set_req(input bit v, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [WEW-1:0] s);
    bus.req_valid = v;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_wstrb = s;
  endtask

  task automatic send(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [WEW-1:0] s);
    bit ok = 1'b0;
    @(posedge clk); #1;
    set_req(1'b1, wr, a, d, s);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Holds a read request for a fixed window with rsp_ready low; returns accepts.
  task automatic stall_fill(input logic [AW-1:0] a, output int accepts);
    accepts = 0;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    set_req(1'b1, 1'b0, a, '0, '0);
    repeat (8) begin
      @(negedge clk);
      if (bus.req_ready) accepts++;
    end
  endtask

  int acc_n, stalls, base_rsp, sent, loop_cyc;
  bit holding, seen;

  initial begin
    set_req(1'b0, 1'b0, '0, '0, '0);
    bus.rsp_ready = 1'b0;

    // Reset: quiet during reset, idle-but-ready just after.
    repeat (3) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_ena", bus.ena, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", bus.req_ready, 1);
    check("post_rst_rsp_valid", bus.rsp_valid, 0);
    check("post_rst_rsp_write", bus.rsp_write, 0);
    check("post_rst_rsp_rdata", bus.rsp_rdata, 0);
    check("post_rst_wea", bus.wea, 0);

    // Write then read back, with read latency measured.
    bus.rsp_ready = 1'b1;
    send(1'b1, 10'd5, 32'hDEADBEEF, 4'hF);
    drain(20);
    check("wr_ack_write", last_write, 1);
    check("wr_ack_rdata", last_rdata, 0);
    send(1'b0, 10'd5, '0, '0);
    drain(20);
    check("rd_data", last_rdata, 32'hDEADBEEF);
    check("rd_latency", rsp_cyc_q[rsp_cyc_q.size()-1] - acc_cyc, LAT + 1);

    // Back-to-back reads of a preloaded region.
    for (int i = 0; i < 16; i++) send(1'b1, AW'(i), DW'(i * 3), 4'hF);
    drain(20);
    rsp_cyc_q.delete();
    stalls = 0;
    @(posedge clk); #1;
    for (int k = 0, g = 0; k < 16 && g < 100; g++) begin
      set_req(1'b1, 1'b0, AW'(k), '0, '0);
      @(negedge clk);
      if (bus.req_ready) k++;
      else stalls++;
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    drain(20);
    check("burst_stalls", stalls, 0);
    check("burst_rsp_count", rsp_cyc_q.size(), 16);
    if (rsp_cyc_q.size() == 16) check("burst_one_per_cycle", rsp_cyc_q[15] - rsp_cyc_q[0], 15);
    check("burst_last_data", last_rdata, 45);

    // Backpressure: exactly C_DEPTH accepts, then reopen one cycle after first pop.
    stall_fill(10'd7, acc_n);
    check("bp_accepts", acc_n, C_DEPTH);
    check("bp_req_ready_low", bus.req_ready, 0);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin seen = 1'b1; break; end
    end
    check("bp_first_pop_seen", seen, 1);
    check("bp_ready_at_pop", bus.req_ready, 0);
    @(negedge clk);
    check("bp_ready_after_pop", bus.req_ready, 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    drain(30);

    // Byte-enabled merge.
    send(1'b1, 10'd2, 32'hFFFFFFFF, 4'hF);
    send(1'b1, 10'd2, 32'h12345678, 4'b0101);
    send(1'b0, 10'd2, '0, '0);
    drain(20);
    check("bwe_merge", last_rdata, 32'hFF34FF78);

    // Reset with reads in flight.
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    set_req(1'b1, 1'b0, 10'd5, '0, '0);
    acc_n = 0;
    for (int i = 0; i < 20 && acc_n < 2; i++) begin
      @(negedge clk);
      if (bus.req_ready) acc_n++;
      if (acc_n < 2) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_req_ready", bus.req_ready, 0);
    check("midrst_ena", bus.ena, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    acc_n = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.rsp_valid) acc_n++;
    end
    check("midrst_no_rsp", acc_n, 0);
    stall_fill(10'd2, acc_n);
    check("midrst_credits", acc_n, C_DEPTH);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    drain(30);
    check("midrst_read_after", last_rdata, 32'hFF34FF78);

    // Randomized traffic with random response backpressure.
    base_rsp = n_rsp;
    sent = 0;
    holding = 1'b0;
    loop_cyc = 0;
    while (sent < N_RAND && loop_cyc < 60000) begin
      @(posedge clk); #1;
      if (!holding) begin
        if ($urandom_range(3) != 0) begin
          holding = 1'b1;
          set_req(1'b1, 1'($urandom_range(1)), AW'($urandom_range(31)), DW'($urandom),
                  WEW'($urandom_range(15)));
        end else begin
          bus.req_valid = 1'b0;
        end
      end
      bus.rsp_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      if (holding && bus.req_ready) begin
        holding = 1'b0;
        sent++;
      end
      loop_cyc++;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    drain(50);
    check("rand_sent", sent, N_RAND);
    check("rand_rsp_count", n_rsp - base_rsp, N_RAND);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
